calltrace_mp: RTL and testbench



---
 rtl/calltrace_mp_pkg.sv | 30 +++
 rtl/calltrace_mp_if.sv | 13 +
 rtl/calltrace_mp_ctx.sv | 86 ++++++++
 rtl/calltrace_mp.sv | 175 +++++++++++++++++
 tb/tb_calltrace_mp.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/calltrace_mp_pkg.sv
// Shared constants for calltrace_mp: IR trigger opcodes, control bit indices
// and the status word layout.
package calltrace_mp_pkg;

  localparam logic [31:0] OP_PUSH = 32'hAFE0_0000;
  localparam logic [31:0] OP_POP  = 32'hC700_000F;

  localparam int CTRL_CLEAR    = 1;
  localparam int CTRL_FREEZE   = 2;
  localparam int CTRL_UNFREEZE = 3;
  localparam int CTRL_BLOCK    = 4;
  localparam int CTRL_UNBLOCK  = 5;
  localparam int CTRL_OVR_ON   = 6;
  localparam int CTRL_OVR_OFF  = 7;

  // Status register layout, MSB first.
  typedef struct packed {
    logic [7:0] max_count;
    logic [7:0] count;
    logic [7:0] sel;
    logic [1:0] rsvd;
    logic       lost;
    logic       unfl;
    logic       frozen;
    logic       ovfl;
    logic       full;
    logic       empty;
  } status_t;

endpackage

// File: rtl/calltrace_mp_if.sv
// IO bus port of calltrace_mp: strobe/write/address request with a registered
// one-wait-cycle response.
interface calltrace_mp_if;
  logic        stb;
  logic        we;
  logic        addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (output stb, we, addr, data_in, input data_out, ack);
  modport slave  (input stb, we, addr, data_in, output data_out, ack);
endinterface

// File: rtl/calltrace_mp_ctx.sv
// Pointer, count, read-cursor and flag state of one circular LNK stack.
// Storage lives in the parent; this block only tracks where things are.
module calltrace_mp_ctx #(
  parameter int SW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic          freeze,
  input  logic          unfreeze,
  input  logic          cur_step,
  input  logic          set_lost,
  output logic [SW-1:0] top_r,
  output logic [SW-1:0] cursor_r,
  output logic [SW:0]   count_r,
  output logic [SW:0]   max_count_r,
  output logic          cur_valid_s,
  output logic          frozen_r,
  output logic          ovfl_r,
  output logic          unfl_r,
  output logic          lost_r
);

  localparam logic [SW:0] FULL = (SW+1)'(1 << SW);

  logic [SW:0] rd_left_r;

  assign cur_valid_s = (rd_left_r != '0);

  // Stack bookkeeping; clear dominates every other event in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_r       <= '0;
      cursor_r    <= '0;
      count_r     <= '0;
      max_count_r <= '0;
      rd_left_r   <= '0;
      frozen_r    <= 1'b0;
      ovfl_r      <= 1'b0;
      unfl_r      <= 1'b0;
      lost_r      <= 1'b0;
    end else if (clr) begin
      top_r       <= '0;
      cursor_r    <= '0;
      count_r     <= '0;
      max_count_r <= '0;
      rd_left_r   <= '0;
      frozen_r    <= 1'b0;
      ovfl_r      <= 1'b0;
      unfl_r      <= 1'b0;
      lost_r      <= 1'b0;
    end else begin
      if (push) begin
        top_r <= top_r + SW'(1);
        if (count_r == FULL) begin
          ovfl_r <= 1'b1;
        end else begin
          count_r <= count_r + (SW+1)'(1);
          if (count_r + (SW+1)'(1) > max_count_r) max_count_r <= count_r + (SW+1)'(1);
        end
      end else if (pop) begin
        if (count_r == '0) begin
          unfl_r <= 1'b1;
        end else begin
          top_r   <= top_r - SW'(1);
          count_r <= count_r - (SW+1)'(1);
        end
      end
      // Frozen reads walk a snapshot from newest toward oldest entry
      if (unfreeze) begin
        frozen_r <= 1'b0;
      end else if (freeze) begin
        frozen_r  <= 1'b1;
        cursor_r  <= top_r - SW'(1);
        rd_left_r <= count_r;
      end else if (cur_step && cur_valid_s) begin
        cursor_r  <= cursor_r - SW'(1);
        rd_left_r <= rd_left_r - (SW+1)'(1);
      end
      if (set_lost) lost_r <= 1'b1;
    end
  end

endmodule

// File: rtl/calltrace_mp.sv
// Multi-process call-trace stacks: NUM_STACKS circular LNK stacks fed by IR
// push/pop triggers and the IO bus. Optional trap freeze: CALLTRACE_MP_TRAP_FREEZE_EN.
module calltrace_mp
  import calltrace_mp_pkg::*;
#(
  parameter int NUM_STACKS = 32,
  parameter int NUM_SLOTS  = 32,
  parameter int DATA_WIDTH = 24,
  parameter int PID_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  calltrace_mp_if.slave         bus,
  input  logic [31:0]           ir_in,
  input  logic [DATA_WIDTH-1:0] lnk_in,
  input  logic [PID_WIDTH-1:0]  cp_pid,
  input  logic                  trap_in
);

  localparam int SW = $clog2(NUM_SLOTS);

  logic [DATA_WIDTH-1:0] mem_r [NUM_STACKS*NUM_SLOTS];

  logic [SW-1:0] top_s       [NUM_STACKS];
  logic [SW-1:0] cursor_s    [NUM_STACKS];
  logic [SW:0]   count_s     [NUM_STACKS];
  logic [SW:0]   max_s       [NUM_STACKS];
  logic          cur_valid_s [NUM_STACKS];
  logic          frozen_s    [NUM_STACKS];
  logic          ovfl_s      [NUM_STACKS];
  logic          unfl_s      [NUM_STACKS];
  logic          lost_s      [NUM_STACKS];

  logic                  push_r, push_d_r, pop_r, pop_d_r;
  logic                  blocked_r, override_r;
  logic [PID_WIDTH-1:0]  ovr_pid_r, sel_s, cdat_s;
  logic [7:0]            ctrl_s;
  logic                  bus_rd_s, bus_wr_s, ctrl_wr_s, bus_hit_s;
  logic                  hw_push_s, hw_pop_s, hw_clash_s, hw_push_ok_s, hw_pop_ok_s;
  logic                  trap_frz_s;
  logic [SW-1:0]         rd_slot_s;
  logic                  rd_valid_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  status_t               status_s;
  logic                  unused_s;

  assign sel_s     = override_r ? ovr_pid_r : cp_pid;
  assign ctrl_s    = bus.data_in[7:0];
  assign cdat_s    = bus.data_in[8 +: PID_WIDTH];
  assign bus_rd_s  = bus.stb & ~bus.addr & ~bus.we;
  assign bus_wr_s  = bus.stb & ~bus.addr & bus.we;
  assign ctrl_wr_s = bus.stb & bus.addr & bus.we;
  assign bus_hit_s = bus_rd_s | bus_wr_s |
                     (ctrl_wr_s & (ctrl_s[CTRL_FREEZE] | ctrl_s[CTRL_UNFREEZE]));

  assign hw_push_s    = push_r & ~push_d_r & ~blocked_r & ~frozen_s[cp_pid];
  assign hw_pop_s     = pop_r & ~pop_d_r & ~blocked_r & ~frozen_s[cp_pid];
  // A bus access to the same stack takes the slot; the IR event is lost
  assign hw_clash_s   = (hw_push_s | hw_pop_s) & bus_hit_s & (sel_s == cp_pid);
  assign hw_push_ok_s = hw_push_s & ~hw_clash_s;
  assign hw_pop_ok_s  = hw_pop_s & ~hw_clash_s;
  assign unused_s     = ^{trap_in, bus.data_in};

`ifdef CALLTRACE_MP_TRAP_FREEZE_EN
  logic trap_d_r;

  // Trap edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_d_r <= 1'b0;
    else        trap_d_r <= trap_in;
  end

  assign trap_frz_s = trap_in & ~trap_d_r & ~frozen_s[cp_pid];
`else
  assign trap_frz_s = 1'b0;
`endif

  for (genvar g = 0; g < NUM_STACKS; g++) begin : g_ctx
    localparam logic [PID_WIDTH-1:0] ID = PID_WIDTH'(g);

    calltrace_mp_ctx #(.SW(SW)) u_ctx (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (ctrl_wr_s & ctrl_s[CTRL_CLEAR] & (cdat_s == ID)),
      .push       ((bus_wr_s & (sel_s == ID)) | (hw_push_ok_s & (cp_pid == ID))),
      .pop        ((bus_rd_s & (sel_s == ID) & ~frozen_s[g]) | (hw_pop_ok_s & (cp_pid == ID))),
      .freeze     ((ctrl_wr_s & ctrl_s[CTRL_FREEZE] & (sel_s == ID)) | (trap_frz_s & (cp_pid == ID))),
      .unfreeze   (ctrl_wr_s & ctrl_s[CTRL_UNFREEZE] & (sel_s == ID)),
      .cur_step   (bus_rd_s & (sel_s == ID) & frozen_s[g]),
      .set_lost   (hw_clash_s & (cp_pid == ID)),
      .top_r      (top_s[g]),
      .cursor_r   (cursor_s[g]),
      .count_r    (count_s[g]),
      .max_count_r(max_s[g]),
      .cur_valid_s(cur_valid_s[g]),
      .frozen_r   (frozen_s[g]),
      .ovfl_r     (ovfl_s[g]),
      .unfl_r     (unfl_s[g]),
      .lost_r     (lost_s[g])
    );
  end

  // Shared storage, one write port for the bus and one for the IR push
  always_ff @(posedge clk) begin
    if (bus_wr_s)     mem_r[{sel_s, top_s[sel_s]}]   <= bus.data_in[DATA_WIDTH-1:0];
    if (hw_push_ok_s) mem_r[{cp_pid, top_s[cp_pid]}] <= lnk_in;
  end

  // Bus read source: top entry when live, snapshot cursor when frozen
  always_comb begin
    rd_slot_s  = top_s[sel_s] - SW'(1);
    rd_valid_s = (count_s[sel_s] != '0);
    if (frozen_s[sel_s]) begin
      rd_slot_s  = cursor_s[sel_s];
      rd_valid_s = cur_valid_s[sel_s];
    end else begin
      rd_slot_s  = top_s[sel_s] - SW'(1);
      rd_valid_s = (count_s[sel_s] != '0);
    end
    rd_word_s = rd_valid_s ? mem_r[{sel_s, rd_slot_s}] : '0;
  end

  // Status word of the selected stack
  always_comb begin
    status_s           = '0;
    status_s.max_count = 8'(max_s[sel_s]);
    status_s.count     = 8'(count_s[sel_s]);
    status_s.sel       = 8'(sel_s);
    status_s.rsvd      = 2'b00;
    status_s.lost      = lost_s[sel_s];
    status_s.unfl      = unfl_s[sel_s];
    status_s.frozen    = frozen_s[sel_s];
    status_s.ovfl      = ovfl_s[sel_s];
    status_s.full      = (count_s[sel_s] == (SW+1)'(NUM_SLOTS));
    status_s.empty     = (count_s[sel_s] == '0);
  end

  // Trigger edge registers and global control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      push_r     <= 1'b0;
      push_d_r   <= 1'b0;
      pop_r      <= 1'b0;
      pop_d_r    <= 1'b0;
      blocked_r  <= 1'b0;
      override_r <= 1'b0;
      ovr_pid_r  <= '0;
    end else begin
      push_r   <= (ir_in == OP_PUSH);
      push_d_r <= push_r;
      pop_r    <= (ir_in == OP_POP);
      pop_d_r  <= pop_r;
      if (ctrl_wr_s) begin
        if (ctrl_s[CTRL_UNBLOCK])     blocked_r <= 1'b0;
        else if (ctrl_s[CTRL_BLOCK])  blocked_r <= 1'b1;
        if (ctrl_s[CTRL_OVR_ON])      ovr_pid_r <= cdat_s;
        if (ctrl_s[CTRL_OVR_OFF])     override_r <= 1'b0;
        else if (ctrl_s[CTRL_OVR_ON]) override_r <= 1'b1;
      end
    end
  end

  // Bus response: ack trails stb by one cycle, data only during ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ack      <= 1'b0;
      bus.data_out <= 32'd0;
    end else begin
      bus.ack <= bus.stb;
      if (bus.stb && !bus.we) bus.data_out <= bus.addr ? status_s : 32'(rd_word_s);
      else                    bus.data_out <= 32'd0;
    end
  end

endmodule

// File: tb/tb_calltrace_mp.sv
// Self-checking bench for calltrace_mp: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based stack model.
module tb_calltrace_mp;

  localparam int NS  = 8;
  localparam int PW  = 3;
  localparam int NSL = 4;
  localparam int DW  = 24;
  localparam logic [31:0] IR_PUSH = 32'hAFE00000;
  localparam logic [31:0] IR_POP  = 32'hC700000F;
  localparam int K_PUSH = 0, K_POP = 1, K_WR = 2, K_RD = 3, K_ST = 4, K_CTRL = 5;

  logic          clk, rst_n, trap_in;
  logic [31:0]   ir_in;
  logic [DW-1:0] lnk_in;
  logic [PW-1:0] cp_pid;
  int            total, bad;

  calltrace_mp_if bus_if ();

  calltrace_mp #(.NUM_STACKS(NS), .NUM_SLOTS(NSL), .DATA_WIDTH(DW), .PID_WIDTH(PW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if.slave), .ir_in(ir_in),
    .lnk_in(lnk_in), .cp_pid(cp_pid), .trap_in(trap_in)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    int          pid;
    logic [31:0] val;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [64];
  int   nv;

  // Reference model: each stack is a queue, newest entry at the back
  int unsigned mq [NS][$];
  int unsigned snap [NS][$];
  int          mmax [NS];
  logic        movf [NS], munfl [NS], mfrz [NS];
  logic        mblk, movr;
  int          movr_pid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_op(input logic w, input logic a, input logic [31:0] d, output logic [31:0] r);
    bus_if.stb = 1'b1; bus_if.we = w; bus_if.addr = a; bus_if.data_in = d;
    tick();
    bus_if.stb = 1'b0; bus_if.we = 1'b0; bus_if.addr = 1'b0; bus_if.data_in = 32'd0;
    check("ack", {31'd0, bus_if.ack}, 32'd1);
    r = bus_if.data_out;
  endtask

  task automatic ir_pulse(input logic [31:0] op, input logic [DW-1:0] v);
    lnk_in = v; ir_in = op;
    tick();
    ir_in = 32'd0;
    tick(); tick(); tick();
  endtask

  task automatic add(input int k, input int p, input logic [31:0] v, input logic [31:0] e);
    vt[nv] = '{k, p, v, e};
    nv++;
  endtask

  function automatic void m_clear(input int s);
    mq[s].delete(); snap[s].delete();
    mmax[s] = 0; movf[s] = 1'b0; munfl[s] = 1'b0; mfrz[s] = 1'b0;
  endfunction

  function automatic void m_push(input int s, input int unsigned v);
    mq[s].push_back(v);
    if (mq[s].size() > NSL) begin
      void'(mq[s].pop_front());
      movf[s] = 1'b1;
    end
    if (mq[s].size() > mmax[s]) mmax[s] = mq[s].size();
  endfunction

  function automatic void m_pop(input int s);
    if (mq[s].size() == 0) munfl[s] = 1'b1;
    else void'(mq[s].pop_back());
  endfunction

  function automatic int unsigned m_read(input int s);
    if (mfrz[s]) return (snap[s].size() > 0) ? snap[s].pop_back() : 0;
    if (mq[s].size() == 0) begin
      munfl[s] = 1'b1;
      return 0;
    end
    return mq[s].pop_back();
  endfunction

  function automatic logic [31:0] m_status(input int s);
    int n;
    n = mq[s].size();
    return {8'(mmax[s]), 8'(n), 8'(s), 2'b00, 1'b0, munfl[s], mfrz[s], movf[s],
            (n == NSL), (n == 0)};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int          op, s, sel;
    int unsigned v;

    clk = 1'b0; rst_n = 1'b0; trap_in = 1'b0; ir_in = 32'd0; lnk_in = '0; cp_pid = '0;
    bus_if.stb = 1'b0; bus_if.we = 1'b0; bus_if.addr = 1'b0; bus_if.data_in = 32'd0;
    total = 0; bad = 0; nv = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_ack", {31'd0, bus_if.ack}, 32'd0);
    check("rst_data", bus_if.data_out, 32'd0);
    bus_op(1'b0, 1'b1, 32'd0, r);
    check("rst_status", r, 32'h0000_0001);

    // Push/pop order on pid 3
    add(K_PUSH, 3, 32'h100, 0); add(K_PUSH, 3, 32'h104, 0); add(K_PUSH, 3, 32'h108, 0);
    add(K_ST, 3, 0, 32'h0303_0300);
    add(K_RD, 3, 0, 32'h108); add(K_RD, 3, 0, 32'h104); add(K_RD, 3, 0, 32'h100);
    add(K_ST, 3, 0, 32'h0300_0301);
    add(K_RD, 3, 0, 32'h0);
    // Wrap-around overflow on pid 0
    for (int i = 1; i <= 6; i++) add(K_PUSH, 0, i, 0);
    add(K_ST, 0, 0, 32'h0404_0006);
    add(K_RD, 0, 0, 32'd6); add(K_RD, 0, 0, 32'd5); add(K_RD, 0, 0, 32'd4); add(K_RD, 0, 0, 32'd3);
    add(K_ST, 0, 0, 32'h0400_0005);
    // Freeze and non-destructive cursor reads on pid 5
    add(K_WR, 5, 32'hFF00_000A, 0); add(K_WR, 5, 32'h0000_000B, 0);
    add(K_CTRL, 5, 32'h04, 0);
    add(K_RD, 5, 0, 32'h0B); add(K_RD, 5, 0, 32'h0A); add(K_RD, 5, 0, 32'h0);
    add(K_ST, 5, 0, 32'h0202_0508);
    add(K_PUSH, 5, 32'h999, 0);
    add(K_ST, 5, 0, 32'h0202_0508);
    add(K_CTRL, 5, 32'h08, 0);
    add(K_RD, 5, 0, 32'h0B);
    add(K_ST, 5, 0, 32'h0201_0500);
    // Override selects stack 7 while cp_pid=1, then clear it
    add(K_CTRL, 1, 32'h0740, 0);
    add(K_WR, 1, 32'h55, 0);
    add(K_ST, 1, 0, 32'h0101_0700);
    add(K_CTRL, 1, 32'h0702, 0);
    add(K_ST, 1, 0, 32'h0000_0701);
    add(K_CTRL, 1, 32'h80, 0);
    add(K_ST, 1, 0, 32'h0000_0101);

    for (int i = 0; i < nv; i++) begin
      cp_pid = PW'(vt[i].pid);
      case (vt[i].kind)
        K_PUSH:  ir_pulse(IR_PUSH, vt[i].val[DW-1:0]);
        K_POP:   ir_pulse(IR_POP, '0);
        K_WR:    bus_op(1'b1, 1'b0, vt[i].val, r);
        K_RD:    begin bus_op(1'b0, 1'b0, 32'd0, r); check($sformatf("vec%0d_rd", i), r, vt[i].exp); end
        K_ST:    begin bus_op(1'b0, 1'b1, 32'd0, r); check($sformatf("vec%0d_st", i), r, vt[i].exp); end
        default: bus_op(1'b1, 1'b1, vt[i].val, r);
      endcase
    end

    // Underflow on a cleared stack, then bus/IR collision on pid 2
    cp_pid = 3'd0;
    bus_op(1'b1, 1'b1, 32'h0002, r);
    ir_pulse(IR_POP, '0);
    bus_op(1'b0, 1'b1, 32'd0, r);
    check("unfl_status", r, 32'h0000_0011);
    cp_pid = 3'd2; lnk_in = 24'h777; ir_in = IR_PUSH;
    tick();
    ir_in = 32'd0;
    bus_op(1'b1, 1'b0, 32'h333, r);
    tick(); tick(); tick();
    bus_op(1'b0, 1'b1, 32'd0, r);
    check("lost_status", r, 32'h0101_0220);
    bus_op(1'b0, 1'b0, 32'd0, r);
    check("lost_data", r, 32'h333);

    // Block suppresses IR events; trap freeze when enabled
    cp_pid = 3'd4;
    bus_op(1'b1, 1'b1, 32'h10, r);
    ir_pulse(IR_PUSH, 24'h41);
    ir_pulse(IR_POP, '0);
    bus_op(1'b0, 1'b1, 32'd0, r);
    check("blocked_status", r, 32'h0000_0401);
    bus_op(1'b1, 1'b1, 32'h20, r);
    ir_pulse(IR_PUSH, 24'h42);
    bus_op(1'b0, 1'b1, 32'd0, r);
    check("unblocked_status", r, 32'h0101_0400);
    trap_in = 1'b1;
    tick(); tick();
    trap_in = 1'b0;
    tick();
    bus_op(1'b0, 1'b1, 32'd0, r);
`ifdef CALLTRACE_MP_TRAP_FREEZE_EN
    check("trap_status", r, 32'h0101_0408);
`else
    check("trap_status", r, 32'h0101_0400);
`endif

    // Randomized run from a known clean state
    for (int i = 0; i < NS; i++) begin
      bus_op(1'b1, 1'b1, 32'((i << 8) | 2), r);
      m_clear(i);
    end
    mblk = 1'b0; movr = 1'b0; movr_pid = 0;
    for (int n = 0; n < 600; n++) begin
      cp_pid = PW'($urandom_range(0, NS - 1));
      sel = movr ? movr_pid : int'(cp_pid);
      op = int'($urandom_range(0, 99));
      if (op < 20) begin
        v = $urandom & 32'h00FF_FFFF;
        ir_pulse(IR_PUSH, v[DW-1:0]);
        if (!mblk && !mfrz[cp_pid]) m_push(int'(cp_pid), v);
      end else if (op < 30) begin
        ir_pulse(IR_POP, '0);
        if (!mblk && !mfrz[cp_pid]) m_pop(int'(cp_pid));
      end else if (op < 45 && !mfrz[sel]) begin
        v = $urandom;
        bus_op(1'b1, 1'b0, v, r);
        m_push(sel, v & 32'h00FF_FFFF);
      end else if (op < 65) begin
        bus_op(1'b0, 1'b0, 32'd0, r);
        check("rand_read", r, m_read(sel));
      end else if (op < 82) begin
        bus_op(1'b0, 1'b1, 32'd0, r);
        check("rand_status", r, m_status(sel));
      end else if (op < 87) begin
        bus_op(1'b1, 1'b1, 32'h04, r);
        mfrz[sel] = 1'b1; snap[sel] = mq[sel];
      end else if (op < 92) begin
        bus_op(1'b1, 1'b1, 32'h08, r);
        mfrz[sel] = 1'b0;
      end else if (op < 94) begin
        s = int'($urandom_range(0, NS - 1));
        bus_op(1'b1, 1'b1, 32'((s << 8) | 2), r);
        m_clear(s);
      end else if (op < 96) begin
        s = int'($urandom_range(0, NS - 1));
        bus_op(1'b1, 1'b1, 32'((s << 8) | 32'h40), r);
        movr = 1'b1; movr_pid = s;
      end else if (op < 98) begin
        bus_op(1'b1, 1'b1, 32'h80, r);
        movr = 1'b0;
      end else begin
        mblk = ~mblk;
        bus_op(1'b1, 1'b1, mblk ? 32'h10 : 32'h20, r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
